// File: rtl/pipeexe_md_pkg.sv
// rtl/pipeexe_md_pkg.sv - shared ALU/mult-div codes and the mult/div state type for the EXE stage
package pipe_pkg;

  localparam int MD_CYCLES = 32;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0001;
  localparam logic [3:0] ALUC_AND  = 4'b0010;
  localparam logic [3:0] ALUC_OR   = 4'b0011;
  localparam logic [3:0] ALUC_XOR  = 4'b0100;
  localparam logic [3:0] ALUC_LUI  = 4'b0101;
  localparam logic [3:0] ALUC_SLL  = 4'b0110;
  localparam logic [3:0] ALUC_SRL  = 4'b0111;
  localparam logic [3:0] ALUC_SLT  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1001;
  localparam logic [3:0] ALUC_SRA  = 4'b1111;

  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MFHI  = 3'd5;
  localparam logic [2:0] MDOP_MFLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  function automatic logic is_start_op(input logic [2:0] op);
    return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
  endfunction

endpackage

// File: rtl/pipeexe_md_if.sv
// rtl/pipeexe_md_if.sv - request/result bundle between the EXE stage and the mult/div unit
interface pipeexe_md_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (output start, op, a, b, input hi, lo, busy, stall);
  modport slave  (input start, op, a, b, output hi, lo, busy, stall);
endinterface

// File: rtl/pipeexe_md_muldiv.sv
// rtl/pipeexe_md_muldiv.sv - iterative mult/div with HI/LO; EXE_FAST_MUL_EN makes mult single-cycle
module muldiv_unit
  import pipe_pkg::*;
(
  input logic         clock,
  input logic         resetn,
  pipeexe_md_if.slave md
);

  md_state_t   state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, acc_hi, acc_lo, hi_q, lo_q;

  logic        is_div, is_sgn, neg_a, neg_b, start_sgn, sub_ok, fast_mul, fsm_start;
  logic [31:0] mag_b, mag_a_in, nxt_hi, nxt_lo, fin_hi, fin_lo;
  logic [32:0] add_sum, shifted, diff;
  logic [63:0] prod_fix;

  assign is_div    = (op_q == MDOP_DIV) || (op_q == MDOP_DIVU);
  assign is_sgn    = (op_q == MDOP_MULT) || (op_q == MDOP_DIV);
  assign neg_a     = is_sgn & a_q[31];
  assign neg_b     = is_sgn & b_q[31];
  assign mag_b     = neg_b ? -b_q : b_q;
  assign start_sgn = (md.op == MDOP_MULT) || (md.op == MDOP_DIV);
  assign mag_a_in  = (start_sgn & md.a[31]) ? -md.a : md.a;

  // acc_lo holds |a|: multiplier bits shift out the bottom, dividend bits shift out the top
  assign add_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_b : 32'd0)};
  assign shifted = {acc_hi, acc_lo[31]};
  assign diff    = shifted - {1'b0, mag_b};
  assign sub_ok  = shifted >= {1'b0, mag_b};

  always_comb begin
    nxt_hi = add_sum[32:1];
    nxt_lo = {add_sum[0], acc_lo[31:1]};
    if (is_div) begin
      nxt_hi = sub_ok ? diff[31:0] : shifted[31:0];
      nxt_lo = {acc_lo[30:0], sub_ok};
    end
  end

  assign prod_fix = (neg_a ^ neg_b) ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};

  always_comb begin
    fin_hi = prod_fix[63:32];
    fin_lo = prod_fix[31:0];
    if (is_div) begin
      if (b_q == 32'd0) begin
        fin_hi = a_q;
        fin_lo = 32'hFFFF_FFFF;
      end else begin
        fin_hi = neg_a ? -nxt_hi : nxt_hi;
        fin_lo = (neg_a ^ neg_b) ? -nxt_lo : nxt_lo;
      end
    end
  end

`ifdef EXE_FAST_MUL_EN
  logic [63:0] fast_a, fast_b, fast_prod;
  assign fast_mul  = md.start && ((md.op == MDOP_MULT) || (md.op == MDOP_MULTU));
  assign fast_a    = {{32{start_sgn & md.a[31]}}, md.a};
  assign fast_b    = {{32{start_sgn & md.b[31]}}, md.b};
  assign fast_prod = fast_a * fast_b;
`else
  assign fast_mul  = 1'b0;
`endif
  assign fsm_start = md.start && !fast_mul;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      op_q   <= MDOP_NONE;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fsm_start) begin
            op_q   <= md.op;
            a_q    <= md.a;
            b_q    <= md.b;
            acc_hi <= 32'd0;
            acc_lo <= mag_a_in;
            cnt    <= 5'd0;
            state  <= BUSY;
          end
`ifdef EXE_FAST_MUL_EN
          else if (fast_mul) begin
            hi_q <= fast_prod[63:32];
            lo_q <= fast_prod[31:0];
          end
`endif
        end
        BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(MD_CYCLES - 1)) begin
            hi_q  <= fin_hi;
            lo_q  <= fin_lo;
            state <= DONE;
          end
        end
        // the op leaves E this cycle, so never restart from DONE
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.busy  = (state != IDLE);
  assign md.stall = ((state == IDLE) && fsm_start) || (state == BUSY);

endmodule

// File: rtl/pipeexe_md.sv
// rtl/pipeexe_md.sv - MIPS32 EXE stage: ALU, result/destination select, mult/div stall; option EXE_FAST_MUL_EN
module pipeexe_md
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        ejal,
  input  logic [3:0]  ealuc,
  input  logic [2:0]  emdop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [31:0] epc4,
  input  logic [4:0]  ern0,
  output logic        mwreg_o,
  output logic        mm2reg_o,
  output logic        mwmem_o,
  output logic [31:0] ealu,
  output logic [31:0] eb_o,
  output logic [4:0]  ern,
  output logic        estall,
  output logic        md_busy
);

  pipeexe_md_if md ();

  assign md.start = is_start_op(emdop);
  assign md.op    = emdop;
  assign md.a     = ea;
  assign md.b     = eb;

  muldiv_unit u_md (
    .clock  (clock),
    .resetn (resetn),
    .md     (md.slave)
  );

  logic [31:0] alua, alub, alu_result;
  logic [4:0]  shamt;

  assign alua  = eshift ? {27'b0, eimm[10:6]} : ea;
  assign alub  = ealuimm ? eimm : eb;
  assign shamt = alua[4:0];

  always_comb begin
    alu_result = 32'd0;
    case (ealuc)
      ALUC_ADD:  alu_result = alua + alub;
      ALUC_SUB:  alu_result = alua - alub;
      ALUC_AND:  alu_result = alua & alub;
      ALUC_OR:   alu_result = alua | alub;
      ALUC_XOR:  alu_result = alua ^ alub;
      ALUC_LUI:  alu_result = alub << 16;
      ALUC_SLL:  alu_result = alub << shamt;
      ALUC_SRL:  alu_result = alub >> shamt;
      ALUC_SRA:  alu_result = $signed(alub) >>> shamt;
      ALUC_SLT:  alu_result = {31'd0, $signed(alua) < $signed(alub)};
      ALUC_SLTU: alu_result = {31'd0, alua < alub};
      default:   alu_result = 32'd0;
    endcase
  end

  always_comb begin
    if (ejal)                    ealu = epc4 + 32'd4;
    else if (emdop == MDOP_MFHI) ealu = md.hi;
    else if (emdop == MDOP_MFLO) ealu = md.lo;
    else                         ealu = alu_result;
  end

  assign ern     = ejal ? 5'd31 : ern0;
  assign eb_o    = eb;
  assign estall  = md.stall;
  assign md_busy = md.busy;

  // a stalled E still holds its instruction, so E/M must see a bubble
  assign mwreg_o  = ewreg  & ~estall;
  assign mm2reg_o = em2reg & ~estall;
  assign mwmem_o  = ewmem  & ~estall;

endmodule
